// File: rtl/accum_cpu.sv
`default_nettype none
// ============================================================================
// Module  : accum_cpu
// Brief   : Multi-cycle accumulator CPU (8-op ISA) with a mem_ready wait-state bus.
//           Optional macro ACPU_CARRY_EN adds a carry flag and turns opcode 7 into JC.
// Revision: 1.0 - initial release
// ============================================================================
module accum_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] adr_bus,
  output logic              rd_mem,
  output logic              wr_mem,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] wr_data,
  input  logic              mem_ready,
  output logic              zero,
`ifdef ACPU_CARRY_EN
  output logic              carry,
`endif
  output logic              halted
);

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_SUB = 3'd1;
  localparam logic [2:0] c_OP_AND = 3'd2;
  localparam logic [2:0] c_OP_LDA = 3'd3;
  localparam logic [2:0] c_OP_STA = 3'd4;
  localparam logic [2:0] c_OP_JMP = 3'd5;
  localparam logic [2:0] c_OP_JZ  = 3'd6;
  localparam logic [2:0] c_OP_7   = 3'd7;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXRD   = 3'd3,
    S_EXWR   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_ac;
  logic [2:0]          w_op;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic                w_zero;

  assign w_op   = r_ir[DATA_W-1 -: 3];
  assign w_addr = r_ir[ADDR_W-1:0];
  assign w_zero = (r_ac == '0);
  assign zero   = w_zero;

`ifdef ACPU_CARRY_EN
  logic r_carry;
  logic w_cout;
  logic w_borrow;
  // One extra bit on each operation exposes carry-out / borrow.
  assign {w_cout, w_sum}    = {1'b0, r_ac} + {1'b0, rd_data};
  assign {w_borrow, w_diff} = {1'b0, r_ac} - {1'b0, rd_data};
  assign carry              = r_carry;
`else
  assign w_sum  = r_ac + rd_data;
  assign w_diff = r_ac - rd_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    rd_mem  = 1'b0;
    wr_mem  = 1'b0;
    adr_bus = '0;
    wr_data = '0;
    halted  = 1'b0;
    case (r_state)
      S_INIT:  w_next = S_FETCH;
      S_FETCH: begin
        rd_mem  = 1'b1;
        adr_bus = r_pc;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_op)
          c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_LDA: w_next = S_EXRD;
          c_OP_STA:                               w_next = S_EXWR;
          c_OP_JMP, c_OP_JZ:                      w_next = S_FETCH;
`ifdef ACPU_CARRY_EN
          default:                                w_next = S_FETCH;
`else
          default:                                w_next = S_HALT;
`endif
        endcase
      end
      S_EXRD: begin
        rd_mem  = 1'b1;
        adr_bus = w_addr;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXWR: begin
        wr_mem  = 1'b1;
        adr_bus = w_addr;
        wr_data = r_ac;
        if (mem_ready) w_next = S_FETCH;
      end
      S_HALT: begin
`ifndef ACPU_CARRY_EN
        halted = 1'b1;
`endif
      end
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
      r_ir <= '0;
      r_ac <= '0;
`ifdef ACPU_CARRY_EN
      r_carry <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir <= rd_data;
            r_pc <= r_pc + ADDR_W'(1);
          end
        end
        S_DECODE: begin
          // Branch target overrides the already-incremented PC.
          if (w_op == c_OP_JMP) r_pc <= w_addr;
          if (w_op == c_OP_JZ && w_zero) r_pc <= w_addr;
`ifdef ACPU_CARRY_EN
          if (w_op == c_OP_7 && r_carry) r_pc <= w_addr;
`endif
        end
        S_EXRD: begin
          if (mem_ready) begin
            case (w_op)
              c_OP_ADD: begin
                r_ac <= w_sum;
`ifdef ACPU_CARRY_EN
                r_carry <= w_cout;
`endif
              end
              c_OP_SUB: begin
                r_ac <= w_diff;
`ifdef ACPU_CARRY_EN
                r_carry <= w_borrow;
`endif
              end
              c_OP_AND: r_ac <= r_ac & rd_data;
              default:  r_ac <= rd_data;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
